// File: rtl/prach_cp_remove.sv
// PRACH cyclic-prefix removal: drops CP_LEN samples after each sof, forwards REPEAT x SEQ_LEN samples.
// Optional PRACH_CP_REMOVE_STATS_EN adds completed/aborted occasion counters.
module prach_cp_remove #(
  parameter int WIDTH   = 32,
  parameter int CP_LEN  = 3168,
  parameter int SEQ_LEN = 24576,
  parameter int REPEAT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_first,
  output logic             dout_last,
  output logic             busy,
  output logic             err_overlap
`ifdef PRACH_CP_REMOVE_STATS_EN
  ,
  output logic [15:0]      occ_done_cnt,
  output logic [15:0]      occ_abort_cnt
`endif
);

  localparam int CPW = $clog2(CP_LEN + 1);
  localparam int SQW = $clog2(SEQ_LEN);

  typedef enum logic [1:0] {S_IDLE, S_CP, S_SEQ} state_t;

  state_t           r_state;
  logic [CPW-1:0]   r_cp_cnt;
  logic [SQW-1:0]   r_seq_cnt;
  logic [1:0]       r_rep_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_dout_first;
  logic             r_dout_last;
  logic             r_busy;
  logic             r_err;

  logic w_seq_last;
  logic w_rep_last;
  logic w_final;
  logic w_fwd;
  logic w_cp_done;

  assign w_seq_last = (r_seq_cnt == SQW'(SEQ_LEN - 1));
  assign w_rep_last = (r_rep_cnt == 2'(REPEAT - 1));
  assign w_final    = (r_state == S_SEQ) && w_seq_last && w_rep_last;
  // A sof on the very last sequence sample still lets that sample through.
  assign w_fwd      = din_valid && (r_state == S_SEQ) && (!sof || w_final);
  assign w_cp_done  = (r_cp_cnt == CPW'(CP_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cp_cnt     <= '0;
      r_seq_cnt    <= '0;
      r_rep_cnt    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_first <= 1'b0;
      r_dout_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_dout_first <= 1'b0;
      r_dout_last  <= 1'b0;
      r_err        <= 1'b0;
      if (din_valid) begin
        if (w_fwd) begin
          r_dout       <= din;
          r_dout_valid <= 1'b1;
          r_dout_first <= (r_seq_cnt == '0);
          r_dout_last  <= w_seq_last;
        end
        if (sof) begin
          // Every sof restarts an occasion with this sample as CP sample 0.
          r_err     <= (r_state != S_IDLE);
          r_cp_cnt  <= CPW'(1);
          r_seq_cnt <= '0;
          r_rep_cnt <= '0;
          r_state   <= (CP_LEN == 1) ? S_SEQ : S_CP;
          r_busy    <= 1'b1;
        end else begin
          case (r_state)
            S_IDLE: r_state <= S_IDLE;
            S_CP: begin
              r_cp_cnt <= r_cp_cnt + CPW'(1);
              if (w_cp_done) begin
                r_state   <= S_SEQ;
                r_seq_cnt <= '0;
                r_rep_cnt <= '0;
              end
            end
            S_SEQ: begin
              if (w_seq_last) begin
                r_seq_cnt <= '0;
                r_rep_cnt <= r_rep_cnt + 2'd1;
                if (w_rep_last) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_seq_cnt <= r_seq_cnt + SQW'(1);
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign dout_first  = r_dout_first;
  assign dout_last   = r_dout_last;
  assign busy        = r_busy;
  assign err_overlap = r_err;

`ifdef PRACH_CP_REMOVE_STATS_EN
  logic [15:0] r_done_cnt;
  logic [15:0] r_abort_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt  <= '0;
      r_abort_cnt <= '0;
    end else if (din_valid) begin
      if (w_final)
        r_done_cnt <= r_done_cnt + 16'd1;
      if (sof && (r_state != S_IDLE) && !w_final && (r_abort_cnt != 16'hFFFF))
        r_abort_cnt <= r_abort_cnt + 16'd1;
    end
  end

  assign occ_done_cnt  = r_done_cnt;
  assign occ_abort_cnt = r_abort_cnt;
`endif

endmodule

// File: tb/tb_prach_cp_remove.sv
// Randomized + directed bench for prach_cp_remove, checked against a sample-index occasion model.
module tb_prach_cp_remove;
  localparam int WIDTH   = 32;
  localparam int CP_LEN  = 4;
  localparam int SEQ_LEN = 8;
  localparam int REPEAT  = 2;
  localparam int TOTAL   = CP_LEN + REPEAT * SEQ_LEN;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             sof = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, dout_first, dout_last, busy, err_overlap;
`ifdef PRACH_CP_REMOVE_STATS_EN
  logic [15:0]      occ_done_cnt, occ_abort_cnt;
`endif

  prach_cp_remove #(.WIDTH(WIDTH), .CP_LEN(CP_LEN), .SEQ_LEN(SEQ_LEN), .REPEAT(REPEAT)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .dout(dout), .dout_valid(dout_valid), .dout_first(dout_first), .dout_last(dout_last),
    .busy(busy), .err_overlap(err_overlap)
`ifdef PRACH_CP_REMOVE_STATS_EN
    , .occ_done_cnt(occ_done_cnt), .occ_abort_cnt(occ_abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: pos = index of the next sample within the occasion, -1 when idle.
  int          pos = -1;
  logic [31:0] e_dout = '0;
  bit          e_dv, e_first, e_last, e_err, e_busy;
  int          e_done = 0, e_abort = 0, m_err = 0;
  int          mq_data[$], mq_first[$], mq_last[$];

  task automatic model_reset();
    pos = -1; e_dout = '0; e_dv = 0; e_first = 0; e_last = 0; e_err = 0; e_busy = 0;
    e_done = 0; e_abort = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [31:0] d);
    int idx;
    bit fwd;
    e_dv = 0; e_first = 0; e_last = 0; e_err = 0;
    if (!rst_n) begin model_reset(); return; end
    if (!v) return;
    idx = pos;
    fwd = (idx >= CP_LEN) && (!s || idx == TOTAL - 1);
    if (fwd) begin
      e_dv = 1; e_dout = d;
      e_first = ((idx - CP_LEN) % SEQ_LEN == 0);
      e_last  = ((idx - CP_LEN) % SEQ_LEN == SEQ_LEN - 1);
      mq_data.push_back(int'(d)); mq_first.push_back(int'(e_first)); mq_last.push_back(int'(e_last));
      if (idx == TOTAL - 1) e_done++;
    end
    if (s) begin
      if (pos >= 0) begin
        e_err = 1; m_err++;
        if (!(fwd && idx == TOTAL - 1) && e_abort < 65535) e_abort++;
      end
      pos = 1;
    end else if (pos >= 0) begin
      pos++;
      if (pos == TOTAL) pos = -1;
    end
    e_busy = (pos >= 0);
  endtask

  // Single compare process: every falling edge.
  always @(negedge clk) begin
    check("dout_valid", {31'd0, dout_valid}, {31'd0, e_dv});
    check("busy", {31'd0, busy}, {31'd0, e_busy});
    check("err_overlap", {31'd0, err_overlap}, {31'd0, e_err});
    check("dout", dout, e_dout);
    if (e_dv) begin
      check("dout_first", {31'd0, dout_first}, {31'd0, e_first});
      check("dout_last", {31'd0, dout_last}, {31'd0, e_last});
    end
`ifdef PRACH_CP_REMOVE_STATS_EN
    check("occ_done_cnt", {16'd0, occ_done_cnt}, 32'(e_done % 65536));
    check("occ_abort_cnt", {16'd0, occ_abort_cnt}, 32'(e_abort));
`endif
  end

  task automatic cycle(input bit v, input bit s, input logic [31:0] d);
    din_valid = v; sof = s; din = d;
    @(posedge clk);
    model_step(v, s, d);
    @(negedge clk);
    $display("cyc v=%0b sof=%0b din=%0h -> exp dv=%0b dout=%0h first=%0b last=%0b err=%0b busy=%0b",
             v, s, d, e_dv, e_dout, e_first, e_last, e_err, e_busy);
  endtask

  task automatic clear_q();
    mq_data.delete(); mq_first.delete(); mq_last.delete();
  endtask

  function automatic int qsum(input int q[$]);
    int t = 0;
    foreach (q[i]) t += q[i];
    return t;
  endfunction

  int err0;

  initial begin
    @(posedge clk);
    @(negedge clk);
    check("rst_dout", dout, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) cycle(0, 0, 0);

    // Contiguous occasion
    clear_q(); err0 = m_err;
    for (int i = 0; i < 20; i++) cycle(1, i == 0, 32'(i));
    check("t1_cnt", 32'(mq_data.size()), 32'd16);
    check("t1_d0", 32'(mq_data[0]), 32'd4);
    check("t1_d15", 32'(mq_data[15]), 32'd19);
    check("t1_first12", 32'(mq_first[8]), 32'd1);
    check("t1_last11", 32'(mq_last[7]), 32'd1);
    check("t1_nfirst", 32'(qsum(mq_first)), 32'd2);
    check("t1_busy_end", {31'd0, e_busy}, 32'd0);
    repeat (3) cycle(0, 0, 0);

    // Same stream with gaps
    clear_q();
    for (int i = 0; i < 20; i++) begin
      cycle(1, i == 0, 32'(i));
      cycle(0, 0, 32'hDEAD);
    end
    check("t2_cnt", 32'(mq_data.size()), 32'd16);
    check("t2_nlast", 32'(qsum(mq_last)), 32'd2);
    repeat (3) cycle(0, 0, 0);

    // Abort at sample 9
    clear_q(); err0 = m_err;
    for (int i = 0; i < 32; i++) cycle(1, i == 0 || i == 9, 32'(i));
    check("t3_err", 32'(m_err - err0), 32'd1);
    check("t3_cnt", 32'(mq_data.size()), 32'd21);
    check("t3_resume", 32'(mq_data[5]), 32'd13);
    check("t3_first13", 32'(mq_first[5]), 32'd1);
    check("t3_nlast", 32'(qsum(mq_last)), 32'd2);
    repeat (3) cycle(0, 0, 0);

    // sof on final sample 19
    clear_q(); err0 = m_err;
    for (int i = 0; i < 40; i++) cycle(1, i == 0 || i == 19, 32'(i));
    check("t4_err", 32'(m_err - err0), 32'd1);
    check("t4_d15", 32'(mq_data[15]), 32'd19);
    check("t4_last19", 32'(mq_last[15]), 32'd1);
    check("t4_next", 32'(mq_data[16]), 32'd23);
    check("t4_first23", 32'(mq_first[16]), 32'd1);
    check("t4_cnt", 32'(mq_data.size()), 32'd32);
    repeat (3) cycle(0, 0, 0);

    // Async reset at sample 7 mid-SEQ
    for (int i = 0; i < 7; i++) cycle(1, i == 0, 32'(i));
    din_valid = 1'b1; sof = 1'b0; din = 32'd7;
    #2 rst_n = 1'b0;
    #1;
    check("arst_dv", {31'd0, dout_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_dout", dout, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    for (int i = 8; i < 24; i++) cycle(1, 0, 32'(i));
    check("post_rst_cnt", 32'(mq_data.size()), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, $urandom);
    repeat (4) cycle(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prach_cp_remove.md
# prach_cp_remove

Cyclic-prefix removal stage of the long-sequence PRACH receive path: sits between the time-domain sample stream (after fixed-latency alignment delays) and the sequence FFT/buffer. It watches for an occasion-start strobe, discards the cyclic-prefix samples, and forwards exactly the sequence samples, with per-repetition first/last markers. Output is registered so downstream alignment delays can be sized against a fixed 1-cycle latency.

## Interface
- WIDTH, 32, packed IQ sample width (I in upper half, Q in lower half; block does not interpret it)
- CP_LEN, 3168, cyclic-prefix length in valid samples; legal range 1..65535
- SEQ_LEN, 24576, sequence length per repetition in valid samples; legal range 2..2^20
- REPEAT, 1, sequence repetitions per occasion; legal range 1..4
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- din  in  WIDTH  input sample
- din_valid  in  1  din qualifier; no backpressure, one sample per asserted cycle
- sof  in  1  occasion start; meaningful only when din_valid=1; that sample is CP sample 0
- dout  out  WIDTH  output sample (held when dout_valid=0)
- dout_valid  out  1  dout qualifier
- dout_first  out  1  first sample of each repetition, qualified by dout_valid
- dout_last  out  1  last sample of each repetition, qualified by dout_valid
- busy  out  1  high while an occasion is in progress (state != IDLE)
- err_overlap  out  1  one-cycle pulse: sof received while busy

## Operation
- States: IDLE, CP, SEQ. Counters: cp_cnt (ceil log2 CP_LEN+1 bits), seq_cnt (ceil log2 SEQ_LEN bits), rep_cnt (2 bits).
- Only cycles with din_valid=1 advance any counter or state; din_valid=0 freezes everything.
- IDLE: sof&din_valid -> CP, cp_cnt=1. sof without din_valid ignored. Samples without sof dropped.
- CP: each valid sample increments cp_cnt; the sample taking cp_cnt to CP_LEN is still dropped and moves to SEQ with seq_cnt=0, rep_cnt=0. With CP_LEN=1, sof sample -> SEQ directly.
- SEQ: each valid sample forwarded; dout_first when seq_cnt=0; dout_last when seq_cnt=SEQ_LEN-1, then seq_cnt wraps to 0 and rep_cnt increments. Last sample of rep REPEAT-1 -> IDLE.
- sof&din_valid in CP or SEQ: abort current occasion (no dout_last emitted for it), pulse err_overlap, restart exactly as from IDLE with that sample as CP sample 0.
- sof&din_valid on the final SEQ sample: final sample forwarded with dout_last; err_overlap pulses; next state CP with cp_cnt=1 (not an abort).
- Exactly REPEAT*SEQ_LEN dout_valid pulses per non-aborted occasion.

## Timing
- Latency din -> dout: 1 cycle; dout_first/last/valid aligned with dout.
- busy: registered, high the cycle after the sof sample, low the cycle after the final sample; reflects next-state register.
- err_overlap: asserted the cycle after the offending sof sample, one cycle wide.
- Reset: state=IDLE, all counters 0, dout=0, dout_valid=0, dout_first=0, dout_last=0, busy=0, err_overlap=0. Reset mid-occasion discards it; no outputs until next sof.
- Throughput: one sample per clk, no stall cycles at state transitions.

## Configuration
- PRACH_CP_REMOVE_STATS_EN defined: adds outputs occ_done_cnt (16 bits, increments on each completed occasion, wraps 65535->0) and occ_abort_cnt (16 bits, increments on each err_overlap abort, saturates at 65535); both reset to 0, update the cycle after the event.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- CP_LEN=4, SEQ_LEN=8, REPEAT=2; sof with samples 0..19 contiguous -> dout = 4..19 (16 outputs), first on 4 and 12, last on 11 and 19, busy falls after 19.
- Same stream with din_valid toggling 1/0 -> same 16 outputs/markers, gaps follow input gaps, no extra pulses.
- Second sof at input sample 9 -> err_overlap one pulse, sample 9 treated as CP 0, outputs resume at sample 13 with dout_first; no dout_last for aborted occasion.
- sof exactly on final sample 19 -> sample 19 out with dout_last, err_overlap pulse, next occasion outputs begin 4 valid samples later.
- rst_n asserted at input sample 7 mid-SEQ -> all outputs 0 asynchronously; samples without sof after release produce no dout_valid.
- STATS_EN build: 3 complete occasions + 1 abort -> occ_done_cnt=3, occ_abort_cnt=1.
